matrix_inv: RTL and testbench
=============================

MATRIX_INV -- requirements
Module: matrix_inv

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: one-cycle request to invert the current a, b, c, d.
REQ-004 SHALL have ports a, b, c, d, input, 16 bit signed Q2.14 each: the matrix [[a b];[c d]].
REQ-005 SHALL have ports a_inv, b_inv, c_inv, d_inv, output, 16 bit signed Q2.14, registered: the inverse.
REQ-006 SHALL have port error, output, 1 bit, registered: 1 means the last matrix was singular.

Function
REQ-007 SHALL latch a, b, c, d at the rising edge where start=1 and the FSM is IDLE (call this edge k).
- start in any other state is ignored.
REQ-008 SHALL use FSM states IDLE -> DET -> DIV -> OUT -> IDLE; at edge k the FSM enters DET.
REQ-009 In DET, SHALL compute det = a*d - b*c as a 33-bit signed Q4.28 value, registered at k+1.
REQ-010 If det == 0:
- SHALL go directly to IDLE;
- at edge k+2, SHALL set error=1 and all four outputs to 0.
REQ-011 If det != 0, SHALL compute recip = floor(2^42 / |det|), 43-bit unsigned, using a restoring divider:
- one quotient bit per cycle;
- 43 cycles in DIV, edges k+2..k+44.
REQ-012 In OUT, SHALL form each output as sign * sat(floor(|adj| * recip / 2^14)):
- adj = d for a_inv, -b for b_inv, -c for c_inv, a for d_inv;
- sign = sign(adj) XOR sign(det);
- magnitudes truncate toward zero.
REQ-013 Saturation SHALL apply as follows:
- positive results above 32767 clamp to 32767;
- negative results below -32768 clamp to -32768;
- saturation does not set error.
REQ-014 For a nonsingular matrix, SHALL register all four outputs with error=0 at edge k+45 (45-cycle latency).
REQ-015 Outputs and error SHALL hold their values until the next result update; inputs may change freely after edge k.
REQ-016 An |adj| of 32768 (input -32768) SHALL be handled without overflow; magnitude paths are 17 bits.

Reset
REQ-017 On reset=1 at a clock edge, SHALL clear the FSM to IDLE, the outputs to 0, and error to 0.
REQ-018 Reset SHALL take priority over start.
REQ-019 Reset mid-operation SHALL abort the computation; no result is produced afterwards.

Structure
REQ-020 SHALL place the following in a shared package:
- FSM state encoding;
- constants DATA_W=16, FRAC=14, DIV_BITS=43;
- the Q2.14 saturation limits.
REQ-021 SHALL implement the divider as one sub-module, seq_divider: start, dividend, divisor, quotient, done.
REQ-022 Multipliers and saturation SHALL stay inline in matrix_inv.

Verification
REQ-023 Identity: a=d=16384, b=c=0, pulse start -> after 45 cycles a_inv=d_inv=16384, b_inv=c_inv=0, error=0.
REQ-024 a=8192, b=4096, c=2048, d=12288 -> recip=47662; a_inv=32767 (saturated), b_inv=-11915, c_inv=-5957, d_inv=23831, error=0.
REQ-025 Singular: a=1, b=2, c=2, d=4 -> 2 cycles after start, error=1 and all outputs 0.
REQ-026 Negative det: a=4096, b=8192, c=4096, d=4096 (det=-2^24) -> a_inv=-32768, b_inv=32767, c_inv=32767, d_inv=-32768, error=0.
REQ-027 Busy/reset: a second start during DIV is ignored; reset asserted during DIV returns to IDLE with outputs 0 and no later update.

Source files
------------

// File: rtl/matrix_inv_pkg.sv
// Shared types and constants for the 2x2 Q2.14 matrix inverter.
package matrix_inv_pkg;
  localparam int DATA_W   = 16;
  localparam int FRAC     = 14;
  localparam int DIV_BITS = 43;
  localparam int DET_W    = 33;               // Q4.28 determinant
  localparam int DEN_W    = 32;               // |det| <= 2^31 fits unsigned 32
  localparam int MAG_W    = 17;               // |adj| up to 32768
  localparam int PROD_W   = MAG_W + DIV_BITS; // |adj| * recip
  localparam int SCL_W    = PROD_W - FRAC;    // product rescaled to Q2.14

  localparam logic signed [DATA_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [DATA_W-1:0] SAT_MIN = 16'sh8000;
  localparam logic [MAG_W-1:0]         NEG_LIM = 17'd32768; // |SAT_MIN|

  // 2^42: numerator of the reciprocal of |det|
  localparam logic [DIV_BITS-1:0] RECIP_NUM = {1'b1, {(DIV_BITS-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DET, DIV, OUT} state_t;
endpackage

// File: rtl/matrix_inv_divider.sv
// Restoring unsigned divider, one quotient bit per clock.
module seq_divider
  import matrix_inv_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [DIV_BITS-1:0] dividend,
  input  logic [DEN_W-1:0]    divisor,
  output logic [DIV_BITS-1:0] quotient,
  output logic                done
);
  logic [DIV_BITS-1:0] dvd_q, quo_q;
  logic [DEN_W-1:0]    den_q;
  logic [DEN_W:0]      rem_q, rem_sh;
  logic [5:0]          cnt_q;
  logic                busy_q, ge;

  // remainder is always < divisor, so its top bit never carries into the shift
  assign rem_sh   = {rem_q[DEN_W-1:0], dvd_q[DIV_BITS-1]};
  assign ge       = rem_sh >= {1'b0, den_q};
  // high during the cycle whose closing edge writes the last quotient bit
  assign done     = busy_q && (cnt_q == 6'(DIV_BITS-1));
  assign quotient = quo_q;

  // load on start, then shift-subtract one bit per edge
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      dvd_q  <= '0;
      den_q  <= '0;
      quo_q  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      rem_q  <= '0;
      dvd_q  <= dividend;
      den_q  <= divisor;
      quo_q  <= '0;
    end else if (busy_q) begin
      rem_q  <= ge ? rem_sh - {1'b0, den_q} : rem_sh;
      dvd_q  <= {dvd_q[DIV_BITS-2:0], 1'b0};
      quo_q  <= {quo_q[DIV_BITS-2:0], ge};
      cnt_q  <= cnt_q + 6'd1;
      if (done) busy_q <= 1'b0;
    end
  end
endmodule

// File: rtl/matrix_inv.sv
// 2x2 Q2.14 matrix inverse: det, reciprocal by sequential divide, scale adjugate.
module matrix_inv
  import matrix_inv_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [DATA_W-1:0] c,
  input  logic signed [DATA_W-1:0] d,
  output logic signed [DATA_W-1:0] a_inv,
  output logic signed [DATA_W-1:0] b_inv,
  output logic signed [DATA_W-1:0] c_inv,
  output logic signed [DATA_W-1:0] d_inv,
  output logic                     error
);
  state_t state, state_nx;

  logic signed [DATA_W-1:0]  a_q, b_q, c_q, d_q;
  logic signed [DET_W-1:0]   det_c, det_q;
  logic [DET_W-1:0]          det_mag;
  logic                      det_zero, div_start, div_done;
  logic [DIV_BITS-1:0]       recip;
  logic [3:0][MAG_W-1:0]     adj;
  logic [3:0][DATA_W-1:0]    res, out_q;
  logic                      err_q;

  assign det_c     = DET_W'(a_q) * DET_W'(d_q) - DET_W'(b_q) * DET_W'(c_q);
  assign det_mag   = det_c[DET_W-1] ? -det_c : det_c;
  assign det_zero  = (det_q == '0);
  // a zero determinant never starts the divider
  assign div_start = (state == DET) && (det_c != '0);

  seq_divider u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (RECIP_NUM),
    .divisor  (DEN_W'(det_mag)),
    .quotient (recip),
    .done     (div_done)
  );

  // adjugate, widened so negating -32768 stays exact
  assign adj[0] = MAG_W'(d_q);
  assign adj[1] = -MAG_W'(b_q);
  assign adj[2] = -MAG_W'(c_q);
  assign adj[3] = MAG_W'(a_q);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [MAG_W-1:0]  mag;
    logic [PROD_W-1:0] prod;
    logic [SCL_W-1:0]  scl;
    logic              neg;
    assign mag  = adj[i][MAG_W-1] ? -adj[i] : adj[i];
    assign prod = PROD_W'(mag) * PROD_W'(recip);
    assign scl  = SCL_W'(prod >> FRAC);
    assign neg  = adj[i][MAG_W-1] ^ det_q[DET_W-1];
    assign res[i] = neg ? ((scl > SCL_W'(NEG_LIM)) ? SAT_MIN : -scl[DATA_W-1:0])
                        : ((scl > SCL_W'(SAT_MAX)) ? SAT_MAX :  scl[DATA_W-1:0]);
  end

  assign a_inv = out_q[0];
  assign b_inv = out_q[1];
  assign c_inv = out_q[2];
  assign d_inv = out_q[3];
  assign error = err_q;

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // next-state: singular matrices bail out of DIV on its first cycle
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = DET;
      DET:  state_nx = DIV;
      DIV:  if (det_zero) state_nx = IDLE;
            else if (div_done) state_nx = OUT;
      OUT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // operand latch, determinant and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      d_q   <= '0;
      det_q <= '0;
      out_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        a_q <= a;
        b_q <= b;
        c_q <= c;
        d_q <= d;
      end
      if (state == DET) det_q <= det_c;
      if (state == DIV && det_zero) begin
        out_q <= '0;
        err_q <= 1'b1;
      end
      if (state == OUT) begin
        out_q <= res;
        err_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_matrix_inv.sv
// Scoreboard bench: stimulus pushes expected results with their due cycle,
// a negedge monitor checks held and updated outputs every cycle.
module tb_matrix_inv;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic signed [15:0] a = '0, b = '0, c = '0, d = '0;
  logic signed [15:0] a_inv, b_inv, c_inv, d_inv;
  logic error;

  matrix_inv dut (
    .clk(clk), .reset(reset), .start(start),
    .a(a), .b(b), .c(c), .d(d),
    .a_inv(a_inv), .b_inv(b_inv), .c_inv(c_inv), .d_inv(d_inv),
    .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][15:0] o;
    logic             e;
    int               due;
  } exp_t;

  exp_t sbq[$];
  exp_t cur, rx;
  int   cyc = 0, checks = 0, errors = 0;
  bit   chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: adopt the next expectation on its due cycle, compare every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      logic [3:0][15:0] act;
      if (sbq.size() > 0 && sbq[0].due == cyc) cur = sbq.pop_front();
      act = {d_inv, c_inv, b_inv, a_inv};
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (act[i] !== cur.o[i]) begin
          errors++;
          $display("FAIL out%0d cyc=%0d got=%0d exp=%0d", i, cyc,
                   $signed(act[i]), $signed(cur.o[i]));
        end
      end
      checks++;
      if (error !== cur.e) begin
        errors++;
        $display("FAIL error cyc=%0d got=%b exp=%b", cyc, error, cur.e);
      end
    end
  end

  task automatic issue(input logic signed [15:0] ia, ib, ic, id, input bit push,
                       input logic signed [15:0] e0, e1, e2, e3,
                       input logic ee, input int lat);
    exp_t x;
    @(negedge clk);
    a = ia; b = ib; c = ic; d = id; start = 1'b1;
    if (push) begin
      x.o = {e3, e2, e1, e0};
      x.e = ee;
      x.due = cyc + 1 + lat;
      sbq.push_back(x);
    end
    @(negedge clk);
    start = 1'b0;
    a = 16'sh5A5A; b = 16'sh1234; c = -16'sd77; d = 16'sd999;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    cur.o = '0; cur.e = 1'b0; cur.due = 0;
    chk_en = 1'b1;

    // identity
    issue(16384, 0, 0, 16384, 1, 16384, 0, 0, 16384, 1'b0, 45);
    idle(48);
    // general case, a_inv saturates
    issue(8192, 4096, 2048, 12288, 1, 32767, -11915, -5957, 23831, 1'b0, 45);
    idle(48);
    // singular
    issue(1, 2, 2, 4, 1, 0, 0, 0, 0, 1'b1, 2);
    idle(4);
    // negative determinant, saturation both ways
    issue(4096, 8192, 4096, 4096, 1, -32768, 32767, 32767, -32768, 1'b0, 45);
    idle(48);
    // -32768 inputs: inverse of -2*I is -0.5*I
    issue(-32768, 0, 0, -32768, 1, -8192, 0, 0, -8192, 1'b0, 45);
    idle(48);
    // second start while busy is ignored
    issue(-16384, 0, 0, -16384, 1, -16384, 0, 0, -16384, 1'b0, 45);
    idle(10);
    issue(16384, 0, 0, 16384, 0, 0, 0, 0, 0, 1'b0, 0);
    idle(50);
    // reset mid-divide aborts and clears
    issue(16384, 0, 0, 16384, 0, 0, 0, 0, 0, 1'b0, 0);
    idle(10);
    @(negedge clk);
    reset = 1'b1;
    rx.o = '0; rx.e = 1'b0; rx.due = cyc + 1;
    sbq.push_back(rx);
    @(negedge clk);
    reset = 1'b0;
    idle(55);
    // reset wins over a simultaneous start
    @(negedge clk);
    reset = 1'b1; start = 1'b1; a = 16384; b = 0; c = 0; d = 16384;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    idle(55);

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL pending got=%0d exp=0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
